apb_uart_tx_feeder: RTL

//  APB slave sitting directly upstream of uart_top. Buffers CPU-written bytes in a TX FIFO.

---
 rtl/uart_feeder_pkg.sv | 27 ++
 rtl/apb_uart_tx_feeder_if.sv | 16 +
 rtl/apb_uart_tx_feeder_sync_fifo.sv | 52 +++++
 rtl/apb_uart_tx_feeder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_feeder_pkg.sv
// Shared definitions for the APB UART TX feeder: register offsets, STATUS/CTRL bit
// positions and the launch sequencer state encoding.
package uart_feeder_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_TXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_RXDATA = 4'hC;

  localparam int unsigned ST_FULL     = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_ACTIVE   = 2;
  localparam int unsigned ST_RX_VALID = 3;
  localparam int unsigned ST_ERR      = 4;
  localparam int unsigned ST_COUNT    = 8;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_FLUSH  = 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } fsm_t;

endpackage

// File: rtl/apb_uart_tx_feeder_if.sv
// APB slave-side bundle for the UART TX feeder (4-bit byte address, 32-bit data).
interface apb_uart_tx_feeder_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_uart_tx_feeder_sync_fifo.sv
// Synchronous byte FIFO with wrapping pointers; simultaneous push/pop is legal even
// when full, and flush wins over a same-cycle push.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/apb_uart_tx_feeder.sv
// APB front end for uart_top: queues TX bytes, launches one frame at a time, captures
// loopback bytes. Optional interrupt output enabled by UART_FEEDER_IRQ_EN.
module apb_uart_tx_feeder
  import uart_feeder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  apb_uart_tx_feeder_if.slave apb,
  output logic                uart_enable,
  output logic                uart_start,
  output logic [7:0]          uart_data_in,
  input  logic                uart_busy,
  input  logic                uart_done,
  input  logic [7:0]          uart_data_out,
  input  logic                uart_error
`ifdef UART_FEEDER_IRQ_EN
  ,
  output logic                irq
`endif
);

  fsm_t             state;
  fsm_t             state_next;
  logic             launch;
  logic             access;
  logic             wr;
  logic             rd;
  logic [1:0]       sel;
  logic             push;
  logic             pop;
  logic             flush;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;
  logic [7:0]       head;
  logic             en;
  logic [7:0]       rxdata;
  logic             rx_valid;
  logic             err_sticky;
  logic [31:0]      prdata_c;
  logic             unused_bits;

  assign access = apb.psel & apb.penable;
  assign wr     = access & apb.pwrite;
  assign rd     = access & ~apb.pwrite;
  assign sel    = apb.paddr[3:2];
  assign pop    = (state == LAUNCH);
  assign push   = wr & (sel == ADDR_TXDATA[3:2]);
  assign flush  = wr & (sel == ADDR_CTRL[3:2]) & apb.pwdata[CTRL_FLUSH];

  assign apb.pready  = 1'b1;
  assign apb.pslverr = wr & (((sel == ADDR_TXDATA[3:2]) & full & ~pop) |
                             (sel == ADDR_RXDATA[3:2]));
  assign apb.prdata  = prdata_c;
  assign uart_enable = en;
  assign unused_bits = ^{apb.pwdata[31:5], apb.pwdata[3:2], apb.paddr[1:0]};

  sync_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .data  (apb.pwdata[7:0]),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // Frame sequencer; a done seen while still waiting for busy ends the frame early.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      IDLE: if (en & ~empty & ~uart_busy) begin
        state_next = LAUNCH;
        launch     = 1'b1;
      end
      LAUNCH:    state_next = WAIT_BUSY;
      WAIT_BUSY: if (uart_done) state_next = IDLE;
                 else if (uart_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (uart_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      uart_start   <= 1'b0;
      uart_data_in <= '0;
    end else begin
      state      <= state_next;
      uart_start <= launch;
      if (launch) uart_data_in <= head;
    end
  end

  // Control and receive capture; a same-cycle capture beats read-clear and W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      rxdata     <= '0;
      rx_valid   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (wr && sel == ADDR_CTRL[3:2]) en <= apb.pwdata[CTRL_EN];
      if (rd && sel == ADDR_RXDATA[3:2]) rx_valid <= 1'b0;
      if (wr && sel == ADDR_STATUS[3:2] && apb.pwdata[ST_ERR]) err_sticky <= 1'b0;
      if (uart_done) begin
        rxdata   <= uart_data_out;
        rx_valid <= 1'b1;
        if (uart_error) err_sticky <= 1'b1;
      end
    end
  end

`ifdef UART_FEEDER_IRQ_EN
  logic irq_rx_en;
  logic irq_empty_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_rx_en    <= 1'b0;
      irq_empty_en <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (wr && sel == ADDR_CTRL[3:2]) begin
        irq_rx_en    <= apb.pwdata[2];
        irq_empty_en <= apb.pwdata[3];
      end
      irq <= (rx_valid & irq_rx_en) | (empty & irq_empty_en);
    end
  end
`endif

  always_comb begin
    prdata_c = '0;
    if (rd) begin
      case (sel)
        ADDR_CTRL[3:2]: begin
          prdata_c[CTRL_EN] = en;
`ifdef UART_FEEDER_IRQ_EN
          prdata_c[2] = irq_rx_en;
          prdata_c[3] = irq_empty_en;
`endif
        end
        ADDR_STATUS[3:2]: begin
          prdata_c[ST_FULL]                    = full;
          prdata_c[ST_EMPTY]                   = empty;
          prdata_c[ST_ACTIVE]                  = (state != IDLE);
          prdata_c[ST_RX_VALID]                = rx_valid;
          prdata_c[ST_ERR]                     = err_sticky;
          prdata_c[ST_COUNT +: FIFO_AW+1]      = count;
        end
        ADDR_RXDATA[3:2]: prdata_c[7:0] = rxdata;
        default: prdata_c = '0;
      endcase
    end
  end

endmodule
